// File: rtl/apb_protocol_checker_if.sv
// APB bus bundle shared by masters, slaves and passive observers.
// The monitor modport sees every bus signal as an input.
interface apb_protocol_checker_if #(
    parameter int PADDR_SIZE = 32,
    parameter int PDATA_SIZE = 32,
    parameter int NUM_SEL    = 1
);
    logic [NUM_SEL-1:0]      PSEL;
    logic                    PENABLE;
    logic [PADDR_SIZE-1:0]   PADDR;
    logic                    PWRITE;
    logic [PDATA_SIZE/8-1:0] PSTRB;
    logic [PDATA_SIZE-1:0]   PWDATA;
    logic                    PREADY;
    logic                    PSLVERR;

    modport master (
        output PSEL, PENABLE, PADDR, PWRITE, PSTRB, PWDATA,
        input  PREADY, PSLVERR
    );

    modport slave (
        input  PSEL, PENABLE, PADDR, PWRITE, PSTRB, PWDATA,
        output PREADY, PSLVERR
    );

    modport monitor (
        input PSEL, PENABLE, PADDR, PWRITE, PSTRB, PWDATA, PREADY, PSLVERR
    );
endinterface

// File: rtl/apb_protocol_checker.sv
// Passive APB3/APB4 protocol checker: tracks IDLE/SETUP/ACCESS, reports coded
// violations (pulse + sticky) and keeps transfer / slave-error / wait statistics.
module apb_protocol_checker #(
    parameter int PADDR_SIZE     = 32,
    parameter int PDATA_SIZE     = 32,
    parameter int NUM_SEL        = 1,
    parameter int TIMEOUT_CYCLES = 16,
    parameter int CNT_W          = 16
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        clr,
    apb_protocol_checker_if.monitor     bus,
    output logic                        err_pulse,
    output logic [2:0]                  err_code,
    output logic [5:0]                  err_sticky,
    output logic [1:0]                  phase,
    output logic [CNT_W-1:0]            txn_cnt,
    output logic [CNT_W-1:0]            slverr_cnt,
    output logic [CNT_W-1:0]            wait_max
);
    localparam int STRB_W = PDATA_SIZE / 8;
    localparam int WAIT_W = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [WAIT_W-1:0] WAIT_SAT    = WAIT_W'(TIMEOUT_CYCLES);
    localparam logic [WAIT_W-1:0] WAIT_SAT_M1 = WAIT_W'(TIMEOUT_CYCLES - 1);
    localparam logic [CNT_W-1:0]  CNT_ONES    = {CNT_W{1'b1}};

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETUP  = 2'd1,
        ACCESS = 2'd2
    } phase_t;

    phase_t                  state_reg;
    logic [NUM_SEL-1:0]      sel_cap_reg;
    logic [PADDR_SIZE-1:0]   addr_cap_reg;
    logic                    write_cap_reg;
    logic [STRB_W-1:0]       strb_cap_reg;
    logic [PDATA_SIZE-1:0]   wdata_cap_reg;
    logic [WAIT_W-1:0]       wait_cnt_reg;
    logic                    err_pulse_reg;
    logic [2:0]              err_code_reg;
    logic [5:0]              err_sticky_reg;
    logic [CNT_W-1:0]        txn_cnt_reg, slverr_cnt_reg, wait_max_reg;

    logic [5:0]              err_vec;
    logic [5:0]              err_sticky_next;
    logic [2:0]              err_code_next;
    logic [WAIT_W-1:0]       wait_cnt_next;
    logic [CNT_W-1:0]        txn_cnt_next, slverr_cnt_next, wait_max_next;
    logic [CNT_W-1:0]        txn_base, slverr_base, wait_max_base, wait_ext;
    logic sel, multi_sel, in_xfer, active, setup_sample, waiting, complete, unstable;

    assign sel          = |bus.PSEL;
    // Clearing the lowest set bit leaves something only if two or more were set.
    assign multi_sel    = (bus.PSEL & (bus.PSEL - NUM_SEL'(1))) != '0;
    assign in_xfer      = state_reg != IDLE;
    assign active       = sel && bus.PENABLE;
    assign setup_sample = sel && !bus.PENABLE;
    assign waiting      = in_xfer && active && !bus.PREADY;
    assign complete     = in_xfer && active && bus.PREADY;

    assign unstable = (bus.PSEL != sel_cap_reg) || (bus.PADDR != addr_cap_reg) ||
                      (bus.PWRITE != write_cap_reg) || (bus.PSTRB != strb_cap_reg) ||
                      (write_cap_reg && (bus.PWDATA != wdata_cap_reg));

    // wait_cnt_reg is zeroed at every capture, so SETUP->ACCESS lands on 1.
    assign wait_cnt_next = (wait_cnt_reg == WAIT_SAT) ? WAIT_SAT : wait_cnt_reg + WAIT_W'(1);

    assign err_vec[0] = multi_sel;
    assign err_vec[1] = bus.PENABLE && (!in_xfer || !sel);
    assign err_vec[2] = in_xfer && !active;
    assign err_vec[3] = in_xfer && active && unstable;
    assign err_vec[4] = waiting && (wait_cnt_reg == WAIT_SAT_M1);
    assign err_vec[5] = setup_sample && !bus.PWRITE && (bus.PSTRB != '0);

    always_comb begin
        err_code_next = 3'd0;
        for (int i = 5; i >= 0; i--) begin
            if (err_vec[i]) err_code_next = 3'(i);
        end
    end

    // Clear acts first, then this cycle's detections land on top of it.
    genvar gi;
    generate
        for (gi = 0; gi < 6; gi++) begin : g_sticky
            assign err_sticky_next[gi] = (err_sticky_reg[gi] & ~clr) | err_vec[gi];
        end
    endgenerate

    always_comb begin
        txn_base        = clr ? '0 : txn_cnt_reg;
        slverr_base     = clr ? '0 : slverr_cnt_reg;
        wait_max_base   = clr ? '0 : wait_max_reg;
        wait_ext        = CNT_W'(wait_cnt_reg);
        txn_cnt_next    = txn_base;
        slverr_cnt_next = slverr_base;
        wait_max_next   = wait_max_base;
        if (complete) begin
            if (txn_base != CNT_ONES) txn_cnt_next = txn_base + CNT_W'(1);
            if (bus.PSLVERR && (slverr_base != CNT_ONES)) slverr_cnt_next = slverr_base + CNT_W'(1);
            if (wait_ext > wait_max_base) wait_max_next = wait_ext;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg      <= IDLE;
            sel_cap_reg    <= '0;
            addr_cap_reg   <= '0;
            write_cap_reg  <= 1'b0;
            strb_cap_reg   <= '0;
            wdata_cap_reg  <= '0;
            wait_cnt_reg   <= '0;
            err_pulse_reg  <= 1'b0;
            err_code_reg   <= 3'd0;
            err_sticky_reg <= 6'd0;
            txn_cnt_reg    <= '0;
            slverr_cnt_reg <= '0;
            wait_max_reg   <= '0;
        end else begin
            err_pulse_reg  <= |err_vec;
            err_code_reg   <= err_code_next;
            err_sticky_reg <= err_sticky_next;
            txn_cnt_reg    <= txn_cnt_next;
            slverr_cnt_reg <= slverr_cnt_next;
            wait_max_reg   <= wait_max_next;
            // A valid setup sample restarts tracking from any phase.
            if (setup_sample) begin
                state_reg     <= SETUP;
                sel_cap_reg   <= bus.PSEL;
                addr_cap_reg  <= bus.PADDR;
                write_cap_reg <= bus.PWRITE;
                strb_cap_reg  <= bus.PSTRB;
                wdata_cap_reg <= bus.PWDATA;
                wait_cnt_reg  <= '0;
            end else if (waiting) begin
                state_reg    <= ACCESS;
                wait_cnt_reg <= wait_cnt_next;
            end else begin
                state_reg <= IDLE;
            end
        end
    end

    assign err_pulse  = err_pulse_reg;
    assign err_code   = err_code_reg;
    assign err_sticky = err_sticky_reg;
    assign phase      = state_reg;
    assign txn_cnt    = txn_cnt_reg;
    assign slverr_cnt = slverr_cnt_reg;
    assign wait_max   = wait_max_reg;
endmodule

// File: doc/apb_protocol_checker.md
Name: apb_protocol_checker

Overview:
- Parametrised, synthesizable APB3/APB4 protocol checker and monitor for the APB agent bus.
- Tracks every transfer through an IDLE/SETUP/ACCESS FSM and supports multiple select lines.
- Flags protocol violations with coded, sticky error reporting.
- Adds a PREADY timeout, per-transfer stability checks and transfer/wait statistics counters; purely passive, drives nothing onto the bus.

Parameters:
- PADDR_SIZE, 32, address width
- PDATA_SIZE, 32, data width (PSTRB width = PDATA_SIZE/8)
- NUM_SEL, 1, number of PSEL lines monitored
- TIMEOUT_CYCLES, 16, consecutive wait states (ACCESS with PREADY low) that raise a timeout error; must be >= 1
- CNT_W, 16, width of statistics counters

Ports:
- clk  in  1  bus clock
- rst  in  1  synchronous active-high reset
- clr  in  1  synchronous clear of err_sticky and statistics (FSM unaffected)
- PSEL  in  NUM_SEL  slave selects
- PENABLE  in  1  enable
- PADDR  in  PADDR_SIZE  address
- PWRITE  in  1  direction
- PSTRB  in  PDATA_SIZE/8  write strobes
- PWDATA  in  PDATA_SIZE  write data
- PREADY  in  1  slave ready
- PSLVERR  in  1  slave error
- err_pulse  out  1  one-cycle error indication
- err_code  out  3  code of highest-priority error in that pulse
- err_sticky  out  6  accumulated error bits, one per code
- phase  out  2  FSM state: 0 IDLE, 1 SETUP, 2 ACCESS
- txn_cnt  out  CNT_W  completed transfers
- slverr_cnt  out  CNT_W  completions with PSLVERR=1
- wait_max  out  CNT_W  largest wait-state count seen in any completed transfer

Behaviour:
- Reset
  - All outputs 0; phase=IDLE.
  - rst mid-transfer abandons the transfer; nothing is counted.
  - The first sample after reset is checked from IDLE.
- Sampling: signals are sampled at posedge clk. "sel" means |PSEL.
- Error codes, priority 0 highest:
  - 0 MULTI_SEL: more than one PSEL bit high.
  - 1 ENABLE_NO_SETUP: PENABLE=1 while phase=IDLE, or PENABLE=1 with sel=0.
  - 2 SETUP_TO_ACCESS: sample following SETUP is not sel && PENABLE.
  - 3 UNSTABLE: in SETUP/ACCESS, PSEL, PADDR, PWRITE, PSTRB differ from values captured at the setup sample. PWDATA is also compared when PWRITE=1.
  - 4 TIMEOUT: the wait counter reaches TIMEOUT_CYCLES; fires once per transfer.
  - 5 STRB_ON_READ: PSTRB != 0 at the setup sample with PWRITE=0.
- Error reporting
  - Errors detected on sample N produce err_pulse=1 and err_code=lowest-index error in cycle N+1.
  - All detected bits are ORed into err_sticky at the same edge.
  - clr and a new error in the same cycle: clear wins, then the new bits are set. err_sticky = new bits only.
- FSM transitions:
  - IDLE:
    - sel && !PENABLE: capture PSEL, PADDR, PWRITE, PSTRB, PWDATA; wait_cnt=0; go to SETUP.
    - Otherwise stay IDLE; error 1 if PENABLE=1.
  - SETUP:
    - sel && PENABLE && PREADY: complete (zero-wait); go to IDLE.
    - sel && PENABLE && !PREADY: go to ACCESS; wait_cnt=1.
    - Anything else: error 2. If the sample is itself a valid setup, recapture and stay SETUP; else go to IDLE.
  - ACCESS:
    - sel && PENABLE && PREADY: complete; go to IDLE.
    - sel && PENABLE && !PREADY: wait_cnt++ (saturating at TIMEOUT_CYCLES); stay ACCESS.
    - PENABLE=0 or sel=0: error 2; go to IDLE (or SETUP if a valid setup sample).
  - Stability (error 3) is checked on every SETUP/ACCESS sample with sel && PENABLE.
- Completion
  - txn_cnt++ and, if PSLVERR, slverr_cnt++; both saturate at all-ones.
  - wait_max = max(wait_max, wait_cnt).
  - All visible the cycle after the completion sample.
- Back-to-back: a setup sample immediately following a completion is legal; IDLE handles it with no idle cycle required.
- Timeout: the transfer keeps being tracked after error 4; a late PREADY still completes and counts.

Test Plan:
- Write, 0 waits, PADDR=0x10, PWDATA=0xA5A5A5A5, PSTRB=0xF -> txn_cnt=1, wait_max=0, err_sticky=0, phase 0->1->0.
- Read with 3 waits, PSLVERR=1 at completion -> txn_cnt=1, slverr_cnt=1, wait_max=3, no error.
- PENABLE=1 from IDLE for one cycle -> err_pulse one cycle later, err_code=1, err_sticky=6'b000010.
- TIMEOUT_CYCLES=4, PREADY held low for 10 access cycles then high -> exactly one err_pulse with code 4 (4th wait sample); txn_cnt=1, wait_max=4.
- PADDR changes mid-wait with NUM_SEL=2 and both PSEL bits high on a setup -> err_code=0, err_sticky=6'b001001 after both events; clr -> err_sticky=0 and counters=0.
- Assert rst during ACCESS -> all outputs 0 next cycle; subsequent clean transfer gives txn_cnt=1.
